// File: rtl/vga_pkg.sv
// Shared definitions for the copper sequencer: instruction fields, opcodes, FSM states.
package vga_pkg;

  localparam int unsigned InstrW = 16;

  // Instruction field positions
  localparam int unsigned OpHi   = 15;
  localparam int unsigned OpLo   = 14;
  localparam int unsigned LineHi = 9;
  localparam int unsigned LineLo = 0;
  localparam int unsigned AddrHi = 11;
  localparam int unsigned AddrLo = 8;
  localparam int unsigned DataHi = 7;
  localparam int unsigned DataLo = 0;

  typedef enum logic [1:0] {
    OpWait  = 2'b00,
    OpWrite = 2'b01,
    OpNop   = 2'b10,
    OpEnd   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWait  = 3'd3,
    StHalt  = 3'd4
  } state_e;

  function automatic op_e get_op(input logic [InstrW-1:0] w);
    return op_e'(w[OpHi:OpLo]);
  endfunction

  function automatic logic [9:0] get_line(input logic [InstrW-1:0] w);
    return w[LineHi:LineLo];
  endfunction

  function automatic logic [3:0] get_addr(input logic [InstrW-1:0] w);
    return w[AddrHi:AddrLo];
  endfunction

  function automatic logic [7:0] get_data(input logic [InstrW-1:0] w);
    return w[DataHi:DataLo];
  endfunction

endpackage

// File: rtl/vga_copper_ram.sv
// Display-list RAM: one write port, one synchronous read port with read enable.
// A read and write to the same entry on one edge returns the old contents.
module vga_copper_ram
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [InstrW-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [InstrW-1:0] rdata
);

  logic [InstrW-1:0] mem [DEPTH];

  // CPU write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data is held when re is low so a stalled instruction stays visible
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vga_copper.sv
// Copper-style display-list sequencer: fetches 16-bit instructions each frame and
// issues timed register writes to the video datapath.
module vga_copper
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned REG_AW = 4,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              list_we,
  input  logic [PW-1:0]     list_addr,
  input  logic [15:0]       list_wdata,
  input  logic [9:0]        y,
  input  logic              blank,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic [PW-1:0]     pc,
  output logic              halted
);

  localparam logic [PW-1:0] PcLast = PW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic [9:0]        y_q;
  logic              frame_start;
  logic              ram_re;
  logic [15:0]       ram_rdata;
  logic              step;
  op_e               op;

  vga_copper_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (list_we),
    .waddr(list_addr),
    .wdata(list_wdata),
    .re   (ram_re),
    .raddr(pc_q),
    .rdata(ram_rdata)
  );

  assign frame_start = (y_q != 10'd0) && (y == 10'd0);
  assign op          = get_op(ram_rdata);

  // Next-state, pc and register-write decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    ram_re     = 1'b0;
    step       = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      pc_d    = '0;
    end else if (frame_start) begin
      // Restart wins over anything in flight, including a pending write
      state_d = StFetch;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StFetch: begin
          ram_re  = 1'b1;
          state_d = StExec;
        end
        StExec: begin
          unique case (op)
            OpWait: begin
              if (y >= get_line(ram_rdata)) begin
                step = 1'b1;
              end else begin
                state_d = StWait;
              end
            end
            OpWrite: begin
              // Stall in EXEC until the beam is outside the visible area
              if (blank) begin
                reg_we_d   = 1'b1;
                reg_addr_d = REG_AW'(get_addr(ram_rdata));
                reg_data_d = get_data(ram_rdata);
                step       = 1'b1;
              end
            end
            OpNop: begin
              step = 1'b1;
            end
            OpEnd: begin
              state_d = StHalt;
            end
          endcase
        end
        StWait: begin
          if (y >= get_line(ram_rdata)) begin
            step = 1'b1;
          end
        end
        StHalt: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      // Completing the last entry halts instead of wrapping to 0
      if (step) begin
        if (pc_q == PcLast) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
    end
  end

  // State, pc, output and raster-line registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      y_q        <= y;
    end
  end

  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign pc       = pc_q;
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_vga_copper.sv
// Self-checking bench for vga_copper: instruction-level reference interpreter
// compared every cycle, directed scenarios with literal expectations, random phase.
module tb_vga_copper;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       list_we;
  logic [3:0] list_addr;
  logic [15:0] list_wdata;
  logic [9:0] y;
  logic       blank;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;
  logic [3:0] pc;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  vga_copper #(
    .DEPTH (DEPTH),
    .REG_AW(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .list_we   (list_we),
    .list_addr (list_addr),
    .list_wdata(list_wdata),
    .y         (y),
    .blank     (blank),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference interpreter. mode: 0 idle, 1 running, 2 halted.
  // have=0 means the instruction at m_pc still needs its fetch cycle.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_cur;
  int m_mode = 0, m_pc = 0, m_addr = 0, m_data = 0, m_yq = 0;
  bit m_have = 0, m_we = 0, m_valid = 0;

  always @(posedge clk) begin
    bit fs, done;
    fs   = (m_yq != 0) && (y == 0);
    done = 0;
    m_we = 0;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_addr = 0; m_data = 0; m_have = 0; m_valid = 1;
    end else if (!enable) begin
      m_mode = 0; m_pc = 0; m_have = 0;
    end else if (fs) begin
      m_mode = 1; m_pc = 0; m_have = 0;
    end else if (m_mode == 1) begin
      if (!m_have) begin
        m_cur  = m_mem[m_pc];
        m_have = 1;
      end else begin
        case (m_cur[15:14])
          2'b00: done = (int'(y) >= int'(m_cur[9:0]));
          2'b01: if (blank) begin
            m_we = 1; m_addr = int'(m_cur[11:8]); m_data = int'(m_cur[7:0]); done = 1;
          end
          2'b10: done = 1;
          default: m_mode = 2;
        endcase
        if (done) begin
          if (m_pc == DEPTH - 1) m_mode = 2;
          else begin
            m_pc++;
            m_have = 0;
          end
        end
      end
    end
    m_yq = rst_n ? int'(y) : 0;
    if (list_we) m_mem[list_addr] = list_wdata;
  end

  // Per-cycle comparison against the interpreter, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_reg_we", int'(reg_we), int'(m_we));
      chk("cyc_reg_addr", int'(reg_addr), m_addr);
      chk("cyc_reg_data", int'(reg_data), m_data);
      chk("cyc_pc", int'(pc), m_pc);
      chk("cyc_halted", int'(halted), int'(m_mode == 2));
    end
  end

  logic [15:0] prog [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      list_we    = 1'b1;
      list_addr  = 4'(i);
      list_wdata = prog[i];
      tick();
    end
    list_we = 1'b0;
  endtask

  // y goes 797 -> 0; returns after the edge that samples y == 0
  task automatic frame_start();
    y = 10'd797;
    tick();
    y = 10'd0;
    tick();
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [15:0] w;
    r = $urandom_range(0, 9);
    w = 16'($urandom);
    if (r < 3) w = {6'b000000, 10'($urandom_range(0, 799))};
    else if (r < 7) w[15:14] = 2'b01;
    else if (r < 9) w = 16'h8000;
    else w = 16'hC000;
    return w;
  endfunction

  initial begin
    int first, pulses, py, bad, stray, prev, yy;
    rst_n = 1'b0; enable = 1'b0; list_we = 1'b0; list_addr = '0; list_wdata = '0;
    y = '0; blank = 1'b1;
    repeat (3) tick();
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_reg_addr", int'(reg_addr), 0);
    chk("rst_reg_data", int'(reg_data), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    rst_n = 1'b1;
    tick();

    // WRITE 3,0x5A; END
    prog[0] = 16'h435A; prog[1] = 16'hC000;
    load_prog(2);
    enable = 1'b1; blank = 1'b1;
    frame_start();
    first = 0;
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (reg_we && first == 0) begin
        first = i;
        chk("t36_addr", int'(reg_addr), 3);
        chk("t36_data", int'(reg_data), 8'h5A);
      end
    end
    chk("t36_latency", first, 3);
    repeat (3) tick();
    chk("t36_halted", int'(halted), 1);
    chk("t36_model_halted", m_mode, 2);

    // WAIT 100; WRITE 1,0x0F; END
    enable = 1'b0; tick();
    prog[0] = 16'h0064; prog[1] = 16'h410F; prog[2] = 16'hC000;
    load_prog(3);
    enable = 1'b1;
    frame_start();
    pulses = 0; py = 0;
    for (int v = 1; v <= 120; v++) begin
      y = 10'(v);
      tick();
      if (reg_we) begin
        pulses++;
        py = v;
      end
    end
    chk("t37_pulses", pulses, 1);
    chk("t37_after_line", int'(py >= 100), 1);
    chk("t37_addr", int'(reg_addr), 1);
    chk("t37_data", int'(reg_data), 8'h0F);

    // WRITE 2,0xA5 stalled by blank=0
    enable = 1'b0; tick();
    prog[0] = 16'h42A5; prog[1] = 16'hC000;
    load_prog(2);
    enable = 1'b1; blank = 1'b0;
    frame_start();
    tick();
    bad = 0;
    repeat (50) begin
      tick();
      if (reg_we || pc != 4'd0) bad++;
    end
    chk("t38_stall", bad, 0);
    blank = 1'b1;
    tick();
    chk("t38_pulse", int'(reg_we), 1);
    chk("t38_addr", int'(reg_addr), 2);
    chk("t38_data", int'(reg_data), 8'hA5);
    tick();
    chk("t38_one_cycle", int'(reg_we), 0);

    // WAIT 700 interrupted by frame wrap
    enable = 1'b0; tick();
    prog[0] = 16'h02BC; prog[1] = 16'h4411; prog[2] = 16'hC000;
    load_prog(3);
    enable = 1'b1;
    frame_start();
    stray = 0;
    y = 10'd300;
    repeat (10) begin tick(); stray += int'(reg_we); end
    chk("t39_waiting_pc", int'(pc), 0);
    y = 10'd799; tick(); stray += int'(reg_we);
    y = 10'd0; tick(); stray += int'(reg_we);
    repeat (10) begin tick(); stray += int'(reg_we); end
    chk("t39_restart_pc", int'(pc), 0);
    chk("t39_not_halted", int'(halted), 0);
    chk("t39_no_stray", stray, 0);
    y = 10'd700;
    pulses = 0;
    repeat (8) begin tick(); pulses += int'(reg_we); end
    chk("t39_pulses", pulses, 1);
    chk("t39_addr", int'(reg_addr), 4);
    chk("t39_data", int'(reg_data), 8'h11);

    // 16 x NOP
    enable = 1'b0; tick();
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h8000;
    load_prog(DEPTH);
    enable = 1'b1;
    frame_start();
    bad = 0; prev = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (int'(pc) < prev) bad++;
      prev = int'(pc);
      if (i == 30) chk("t40_mid_pc", int'(pc), 15);
      if (i == 30) chk("t40_mid_running", int'(halted), 0);
    end
    chk("t40_no_wrap", bad, 0);
    chk("t40_pc_last", int'(pc), 15);
    chk("t40_halted", int'(halted), 1);
    chk("t40_model_pc", m_pc, 15);

    // enable drop mid-list, then reset mid-WRITE
    enable = 1'b0; tick();
    prog[0] = 16'h8000; prog[1] = 16'h8000; prog[2] = 16'h4577; prog[3] = 16'hC000;
    load_prog(4);
    enable = 1'b1;
    frame_start();
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("t41_en_pc", int'(pc), 0);
    chk("t41_en_halted", int'(halted), 0);
    chk("t41_en_we", int'(reg_we), 0);
    enable = 1'b1; blank = 1'b0;
    frame_start();
    repeat (10) tick();
    chk("t41_stall_pc", int'(pc), 2);
    blank = 1'b1; rst_n = 1'b0;
    tick();
    chk("t41_rst_we", int'(reg_we), 0);
    chk("t41_rst_addr", int'(reg_addr), 0);
    chk("t41_rst_data", int'(reg_data), 0);
    chk("t41_rst_pc", int'(pc), 0);
    chk("t41_rst_halted", int'(halted), 0);
    rst_n = 1'b1;
    tick();

    // Random phase
    enable = 1'b0; tick();
    for (int i = 0; i < DEPTH; i++) prog[i] = rand_instr();
    load_prog(DEPTH);
    enable = 1'b1;
    yy = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      blank = ($urandom_range(0, 9) < 6);
      yy += $urandom_range(0, 30);
      if (yy >= 800) yy = 0;
      y = 10'(yy);
      list_we    = ($urandom_range(0, 19) == 0);
      list_addr  = 4'($urandom_range(0, DEPTH - 1));
      list_wdata = rand_instr();
      tick();
    end
    list_we = 1'b0; rst_n = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
